// File: rtl/ras_pkg.sv
// Shared decode constants, RAS operation type and link-register helper for the
// return-address-stack control stage.
package ras_pkg;

   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [1:0] RVC_Q1 = 2'b01;
   localparam logic [1:0] RVC_Q2 = 2'b10;

   localparam logic [2:0] C_F3_JAL  = 3'b001;
   localparam logic [2:0] C_F3_BEQZ = 3'b110;
   localparam logic [2:0] C_F3_BNEZ = 3'b111;
   localparam logic [3:0] C_F4_JR   = 4'b1000;
   localparam logic [3:0] C_F4_JALR = 4'b1001;

   typedef enum logic [1:0] {RAS_NONE, RAS_PUSH, RAS_POP, RAS_POPPUSH} ras_op_t;

   function automatic logic is_link(input logic [4:0] r);
      return (r == 5'd1) || (r == 5'd5);
   endfunction

endpackage

// File: rtl/ras_hint_decode.sv
// Combinational RV32I/C link-hint decoder: classifies an instruction as a RAS
// push/pop/pop+push, a conditional branch, and whether it is compressed.
module ras_hint_decode
   import ras_pkg::*;
#(
   parameter bit RVC = 1'b1
) (
   input  logic [31:0] instr,
   output ras_op_t     op,
   output logic        is_cond_branch,
   output logic        compressed
);

   logic [4:0] rd;
   logic [4:0] rs1;
   logic [4:0] c_rs2;
   logic       unused_hi;

   assign unused_hi = ^instr[31:20];

   always_comb begin
      rd             = instr[11:7];
      rs1            = instr[19:15];
      c_rs2          = instr[6:2];
      compressed     = (instr[1:0] != 2'b11);
      op             = RAS_NONE;
      is_cond_branch = 1'b0;

      if (!compressed) begin
         case (instr[6:0])
            OP_JAL: begin
               if (is_link(rd)) op = RAS_PUSH;
            end
            OP_JALR: begin
               if (is_link(rd) && is_link(rs1)) begin
                  op = (rd != rs1) ? RAS_POPPUSH : RAS_PUSH;
               end else if (is_link(rd)) begin
                  op = RAS_PUSH;
               end else if (is_link(rs1)) begin
                  op = RAS_POP;
               end
            end
            OP_BRANCH: is_cond_branch = 1'b1;
            default: ;
         endcase
      end else if (RVC) begin
         // In compressed forms rd/rs1 share bits [11:7]
         if (instr[1:0] == RVC_Q1) begin
            if (instr[15:13] == C_F3_JAL) op = RAS_PUSH;
            if ((instr[15:13] == C_F3_BEQZ) || (instr[15:13] == C_F3_BNEZ)) begin
               is_cond_branch = 1'b1;
            end
         end else if ((instr[1:0] == RVC_Q2) && (c_rs2 == 5'd0) && (rd != 5'd0)) begin
            if ((instr[15:12] == C_F4_JR) && is_link(rd)) begin
               op = RAS_POP;
            end else if (instr[15:12] == C_F4_JALR) begin
               op = (rd == 5'd5) ? RAS_POPPUSH : RAS_PUSH;
            end
         end
      end
   end

endmodule

// File: rtl/ras_ctrl.sv
// Return-address-stack control stage: drives stack push/pop/speculation strobes,
// bounds outstanding branches, enforces close timing and forms return predictions.
module ras_ctrl
   import ras_pkg::*;
#(
   parameter int unsigned WIDTH        = 32,
   parameter int unsigned MAX_BRANCHES = 128,
   parameter bit          RVC          = 1'b1,
   localparam int unsigned CNT_W       = $clog2(MAX_BRANCHES + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             dec_valid,
   output logic             dec_ready,
   input  logic [WIDTH-1:0] dec_pc,
   input  logic [31:0]      dec_instr,
   input  logic             res_valid,
   input  logic             res_mispredict,
   output logic             res_ready,
   output logic             ras_push,
   output logic             ras_pop,
   output logic [WIDTH-1:0] ras_din,
   output logic             ras_branch,
   output logic             ras_close_valid,
   output logic             ras_close_invalid,
   input  logic [WIDTH-1:0] ras_dout,
   input  logic             ras_empty,
   output logic             pred_valid,
   output logic [WIDTH-1:0] pred_target,
   output logic             pred_hit,
   output logic [CNT_W-1:0] outstanding
);

   localparam logic [CNT_W-1:0] CntMax = CNT_W'(MAX_BRANCHES);
   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   ras_op_t          op;
   logic             is_cond_branch;
   logic             compressed;

   logic [CNT_W-1:0] count_q, count_d;
   logic             cooldown_q, cooldown_d;
   logic             pend_q, pend_d;
   logic             hit_q, hit_d;

   logic             res_acc;
   logic             flush;
   logic             good_res;
   logic             dec_acc;
   logic             push_acc;
   logic             pop_acc;
   logic             br_acc;

   ras_hint_decode #(
      .RVC (RVC)
   ) u_decode (
      .instr          (dec_instr),
      .op             (op),
      .is_cond_branch (is_cond_branch),
      .compressed     (compressed)
   );

   always_comb begin
      res_ready = !cooldown_q;
      // A resolution with nothing outstanding is dropped without any pulse
      res_acc   = reset_n && res_valid && res_ready && (count_q != '0);
      flush     = res_acc && res_mispredict;
      good_res  = res_acc && !res_mispredict;

      dec_ready = !flush && !(is_cond_branch && (count_q == CntMax));
      dec_acc   = reset_n && dec_valid && dec_ready;
      push_acc  = dec_acc && ((op == RAS_PUSH) || (op == RAS_POPPUSH));
      pop_acc   = dec_acc && ((op == RAS_POP) || (op == RAS_POPPUSH));
      br_acc    = dec_acc && is_cond_branch;

      ras_push          = push_acc;
      ras_pop           = pop_acc;
      ras_branch        = br_acc;
      ras_din           = push_acc ? (dec_pc + (compressed ? WIDTH'(2) : WIDTH'(4))) : '0;
      ras_close_valid   = good_res;
      ras_close_invalid = flush;

      count_d = count_q;
      if (flush) begin
         count_d = '0;
      end else if (good_res && !br_acc) begin
         count_d = count_q - CntOne;
      end else if (br_acc && !good_res) begin
         count_d = count_q + CntOne;
      end

      cooldown_d = good_res;
      pend_d     = pop_acc;
      hit_d      = pop_acc ? !ras_empty : hit_q;

      // Stack read data lands one cycle after the pop; a flush kills it
      pred_valid  = pend_q && !flush;
      pred_target = pred_valid ? ras_dout : '0;
      pred_hit    = pred_valid && hit_q;
      outstanding = count_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q    <= '0;
         cooldown_q <= 1'b0;
         pend_q     <= 1'b0;
         hit_q      <= 1'b0;
      end else begin
         count_q    <= count_d;
         cooldown_q <= cooldown_d;
         pend_q     <= pend_d;
         hit_q      <= hit_d;
      end
   end

   res_no_branch_a : assert property (@(posedge clk) disable iff (!reset_n)
      !(res_valid && res_ready && (count_q == '0)));

endmodule
